// File: rtl/fifo_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// fifo_uart_tx_pkg : shared constants and state encoding for fifo_uart_tx
// Revision: 1.0
// ============================================================================
package fifo_uart_tx_pkg;

   localparam int DATA_W        = 8;
   localparam int NUM_DATA_BITS = 8;

   localparam logic TX_IDLE   = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

   typedef logic [2:0] state_t;

   localparam state_t c_IDLE  = 3'd0;
   localparam state_t c_REQ   = 3'd1;
   localparam state_t c_WAIT  = 3'd2;
   localparam state_t c_START = 3'd3;
   localparam state_t c_DATA  = 3'd4;
   localparam state_t c_STOP  = 3'd5;

endpackage : fifo_uart_tx_pkg
`default_nettype wire

// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ============================================================================
// fifo_uart_tx_if : FIFO read side, enable and serial outputs of fifo_uart_tx
// Revision: 1.0
// ============================================================================
interface fifo_uart_tx_if;
   import fifo_uart_tx_pkg::*;

   logic              enable;
   logic              fifo_empty;
   logic              fifo_wn;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_rn;
   logic              tx;
   logic              busy;
   logic              frame_done;

   modport master (
      output enable, fifo_empty, fifo_wn, fifo_data,
      input  fifo_rn, tx, busy, frame_done
   );

   modport slave (
      input  enable, fifo_empty, fifo_wn, fifo_data,
      output fifo_rn, tx, busy, frame_done
   );

endinterface : fifo_uart_tx_if
`default_nettype wire

// File: rtl/fifo_uart_tx_baud.sv
`default_nettype none
// ============================================================================
// baud_tick_gen : pulses tick on the last clock of every bit period
// Revision: 1.0
// ============================================================================
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int                c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

   logic [c_CNT_W-1:0] r_count;

   assign tick = (r_count == c_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (clear || tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule : baud_tick_gen
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// fifo_uart_tx : drains a synchronous byte FIFO and sends each byte as 8N1
// Revision: 1.0
// ============================================================================
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8
) (
   input  logic           clock,
   input  logic           reset,
   fifo_uart_tx_if.slave  bus
);
   import fifo_uart_tx_pkg::*;

   localparam logic [2:0] c_LAST_BIT = 3'(NUM_DATA_BITS - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_shift;
   logic [2:0]        r_bit_cnt;
   logic              w_tick;
   logic              w_clear;
   logic              w_tx;

   // Restart the bit timer while the byte loads so START gets a full period.
   assign w_clear = (r_state == c_WAIT);

   baud_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clock (clock),
      .reset (reset),
      .clear (w_clear),
      .tick  (w_tick)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (bus.enable && !bus.fifo_empty) w_state_nxt = c_REQ;
         // The FIFO drops a read that collides with a write; fall back and retry.
         c_REQ:   w_state_nxt = (bus.fifo_wn || bus.fifo_empty) ? c_IDLE : c_WAIT;
         c_WAIT:  w_state_nxt = c_START;
         c_START: if (w_tick) w_state_nxt = c_DATA;
         c_DATA:  if (w_tick && (r_bit_cnt == c_LAST_BIT)) w_state_nxt = c_STOP;
         c_STOP:  if (w_tick) w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else begin
         if (r_state == c_WAIT) begin
            r_shift <= bus.fifo_data;
         end else if ((r_state == c_DATA) && w_tick) begin
            r_shift <= {1'b0, r_shift[DATA_W-1:1]};
         end

         if ((r_state == c_DATA) && w_tick) begin
            r_bit_cnt <= (r_bit_cnt == c_LAST_BIT) ? 3'd0 : r_bit_cnt + 3'd1;
         end
      end
   end

   always_comb begin
      w_tx = TX_IDLE;
      case (r_state)
         c_START: w_tx = START_LVL;
         c_DATA:  w_tx = r_shift[0];
         c_STOP:  w_tx = STOP_LVL;
         default: w_tx = TX_IDLE;
      endcase
   end

   assign bus.tx         = w_tx;
   assign bus.fifo_rn    = (r_state == c_REQ);
   assign bus.busy       = (r_state != c_IDLE);
   assign bus.frame_done = (r_state == c_STOP) && w_tick;

endmodule : fifo_uart_tx
`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the team's 8-entry synchronous byte FIFO.
- Drains bytes through the FIFO's rn / DATAOUT / empty read interface.
- Serialises each byte as an 8N1 UART frame on a single tx line.
- Accounts for the FIFO's one-cycle registered read data and its write-over-read priority: a read requested in the same cycle as a write is silently dropped by the FIFO, and this block retries it.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2.
- DATA_W, 8, byte width; fixed at 8, matches the FIFO data width.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset: 0 resets immediately, independent of clock.
- enable  in  1  permits fetching a new byte from the FIFO.
- fifo_empty  in  1  FIFO empty flag.
- fifo_wn  in  1  copy of the FIFO write enable, used to detect a lost read.
- fifo_data  in  8  FIFO DATAOUT, valid the cycle after a successful read.
- fifo_rn  out  1  FIFO read request, one-cycle pulse.
- tx  out  1  serial output; idle level 1.
- busy  out  1  1 whenever state is not IDLE.
- frame_done  out  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (reset=0): state IDLE, shift register 0x00, bit and baud counters 0, fifo_rn=0, tx=1, busy=0, frame_done=0. All take effect immediately, not at the next edge.
- States: IDLE, REQ, WAIT, START, DATA, STOP.
- Outputs are decoded from state and registers only:
  - fifo_rn = (state==REQ).
  - tx = 0 in START, shift[0] in DATA, 1 in all other states.
- IDLE: if enable=1 and fifo_empty=0, go to REQ next cycle; otherwise stay.
- REQ (fifo_rn=1 for exactly this cycle):
  - fifo_wn=1 or fifo_empty=1 this cycle: the read is lost; go to IDLE, which re-evaluates and retries.
  - Otherwise go to WAIT.
- WAIT: fifo_data now holds the read byte. Load it into the shift register at the end of the cycle; go to START.
- START: hold tx=0 for CLKS_PER_BIT cycles; the baud counter runs 0..CLKS_PER_BIT-1.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. At the end of each bit, shift right by one. The bit counter runs 0..7; after bit 7 go to STOP.
- STOP: hold tx=1 for CLKS_PER_BIT cycles. frame_done=1 on its final cycle; then go to IDLE.
- Latency: with IDLE qualifying in cycle 0, REQ is cycle 1, WAIT is cycle 2, and the first START cycle is cycle 3. Frame length is 10*CLKS_PER_BIT cycles.
- Back-to-back bytes: the gap between one stop bit and the next start bit is exactly 3 cycles (IDLE, REQ, WAIT), with tx=1.
- enable deasserted mid-frame: the current frame completes unchanged; enable gates only the IDLE->REQ transition.
- fifo_empty rising mid-frame: no effect on the frame in progress.
- Reset asserted mid-frame: the byte is dropped, tx returns to 1 immediately, and no frame_done is issued.
- Baud counter width is clog2(CLKS_PER_BIT); bit counter is 3 bits. Neither counter wraps except by explicit reload to 0 at the end of a bit.
- Exactly one fifo_rn pulse is issued per attempted read. Each byte is transmitted exactly once; a retried read is not a duplicate, because the FIFO did not advance rptr.

Decomposition:
- Shared package:
  - state enumeration (IDLE, REQ, WAIT, START, DATA, STOP);
  - constants DATA_W=8, NUM_DATA_BITS=8, TX_IDLE=1, START_LVL=0, STOP_LVL=1.
- One sub-module, baud_tick_gen:
  - parameter CLKS_PER_BIT; inputs clock, reset, clear; output tick.
  - tick=1 on the last cycle of each bit period.
  - clear restarts the count; asserted on entry to START.

Test Plan:
- Single byte 0xA5, CLKS_PER_BIT=4, enable=1, FIFO preloaded:
  - fifo_rn=1 in cycle 1 only;
  - tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, from cycle 3;
  - frame_done=1 in cycle 42; busy=0 from cycle 43.
- Collision: fifo_wn=1 during the first REQ cycle:
  - state returns to IDLE and fifo_rn pulses again 2 cycles later;
  - 0xA5 is transmitted exactly once; total fifo_rn pulses = 2.
- Back-to-back 0x01, 0x80, 0xFF:
  - three frames with LSB-first bit patterns;
  - exactly 3 cycles of tx=1 between each stop bit and the next start bit;
  - 3 fifo_rn pulses, FIFO empty at the end.
- Empty FIFO with enable=1 for 100 cycles: fifo_rn=0, tx=1, busy=0 throughout.
- enable dropped during DATA bit 3: the frame completes, frame_done pulses, no further fifo_rn while enable=0 even with fifo_empty=0.
- reset driven to 0 during DATA bit 5 (no clock edge needed):
  - tx=1, busy=0, fifo_rn=0 immediately;
  - after release, the next byte starts with a fresh REQ.
